// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect read path.
//   NUM_SLV        number of slave ports behind the interconnect
//   SLV_IDX_W      width of a slave index / read-data mux select
//   rd_ord_entry_t one ordering-FIFO entry at the default ARLEN width;
//                  the scheduler packs the same fields as {slave_idx, len}
//                  at its own LEN_W
package axi_ic_pkg;

    localparam int NUM_SLV   = 4;
    localparam int SLV_IDX_W = 2;
    localparam int ORD_LEN_W = 8;

    typedef struct packed {
        logic [SLV_IDX_W-1:0] slave_idx;
        logic [ORD_LEN_W-1:0] len;
    } rd_ord_entry_t;

endpackage

// File: rtl/ord_fifo.sv
// Synchronous in-order FIFO with registered count/full/empty flags.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write wdata_i at the tail (ignored while full)
//   pop_i         drop the head entry (ignored while empty)
//   head_o        current head entry, read straight from storage
//   count_o       number of stored entries
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module ord_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags are computed from count_d so they are registered yet exact;
    // a push is never visible at the head in the cycle it is written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/axi_rd_resp_sched.sv
// Read-response scheduler for a 1-master / 4-slave AXI read path.
// Accepted ARs are queued in order; the head entry steers the external
// RDATA/RRESP/RLAST 4:1 mux and gates RVALID/RREADY so R bursts return
// in AR order.
//   ACLK, ARESET       clock, asynchronous active-high reset
//   ar_valid/ar_ready  AR handshake seen at the decoder/slave side
//   ar_slave_sel       decoded target slave of the current AR
//   ar_len             ARLEN of the current AR
//   ar_stall           forces master ARREADY low while the queue is full
//   s_rvalid, s_rlast  per-slave RVALID/RLAST
//   m_rready           master RREADY
//   s_rready           per-slave RREADY, one-hot or zero
//   m_rvalid           RVALID to the master
//   rd_sel             select for the external R-channel 4:1 mux
//   outstanding        number of queued ARs
//   len_err            one-cycle pulse after a burst-length mismatch
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | queue empty; rd_sel holds, no R traffic is passed
// ST_BURST | queue non-empty; head slave's R channel is connected
module axi_rd_resp_sched
    import axi_ic_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic [SLV_IDX_W-1:0] ar_slave_sel,
    input  logic [LEN_W-1:0]     ar_len,
    output logic                 ar_stall,
    input  logic [NUM_SLV-1:0]   s_rvalid,
    input  logic [NUM_SLV-1:0]   s_rlast,
    input  logic                 m_rready,
    output logic [NUM_SLV-1:0]   s_rready,
    output logic                 m_rvalid,
    output logic [SLV_IDX_W-1:0] rd_sel,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 len_err
);

    localparam int ENT_W = SLV_IDX_W + LEN_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [ENT_W-1:0]     head;
    logic [SLV_IDX_W-1:0] head_slave;
    logic [LEN_W-1:0]     head_len;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [0:0]           state;
    logic [SLV_IDX_W-1:0] rd_sel_q;
    logic [LEN_W-1:0]     beat_cnt_q;
    logic [LEN_W-1:0]     beat_cnt_d;
    logic                 len_err_q;
    logic                 len_err_d;
    logic                 push;
    logic                 beat;
    logic                 last;
    logic                 pop;

    assign push = ar_valid & ar_ready & ~fifo_full;

    ord_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W),
        .CNT_W (CNT_W)
    ) u_ord_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({ar_slave_sel, ar_len}),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_slave, head_len} = head;

    // State is a direct image of the registered empty flag.
    assign state = fifo_empty ? ST_IDLE : ST_BURST;

    always_comb begin
        rd_sel   = rd_sel_q;
        m_rvalid = 1'b0;
        s_rready = '0;
        if (state == ST_BURST) begin
            rd_sel               = head_slave;
            m_rvalid             = s_rvalid[head_slave];
            s_rready[head_slave] = m_rready;
        end
    end

    assign beat = m_rvalid & m_rready;
    assign last = s_rlast[rd_sel];
    assign pop  = beat & last;

    // A missing RLAST does not pop; the counter keeps running (saturating)
    // so the eventual late RLAST is flagged as well.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        if (beat) begin
            if (last) begin
                beat_cnt_d = '0;
                len_err_d  = (beat_cnt_q != head_len);
            end else begin
                len_err_d = (beat_cnt_q == head_len);
                if (beat_cnt_q != '1) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_sel_q   <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            rd_sel_q   <= rd_sel;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign ar_stall    = fifo_full;
    assign outstanding = fifo_count;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_axi_rd_resp_sched.sv
module tb_axi_rd_resp_sched;
    import axi_ic_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = 3;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             ar_valid;
    logic             ar_ready;
    logic [1:0]       ar_slave_sel;
    logic [7:0]       ar_len;
    logic             ar_stall;
    logic [3:0]       s_rvalid;
    logic [3:0]       s_rlast;
    logic             m_rready;
    logic [3:0]       s_rready;
    logic             m_rvalid;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] outstanding;
    logic             len_err;

    axi_rd_resp_sched #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .ar_valid     (ar_valid),
        .ar_ready     (ar_ready),
        .ar_slave_sel (ar_slave_sel),
        .ar_len       (ar_len),
        .ar_stall     (ar_stall),
        .s_rvalid     (s_rvalid),
        .s_rlast      (s_rlast),
        .m_rready     (m_rready),
        .s_rready     (s_rready),
        .m_rvalid     (m_rvalid),
        .rd_sel       (rd_sel),
        .outstanding  (outstanding),
        .len_err      (len_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       av;
        logic       ar;
        logic [1:0] sel;
        logic [7:0] len;
        logic [3:0] rv;
        logic [3:0] rl;
        logic       mr;
        logic       x_stall;
        logic [3:0] x_rready;
        logic       x_mvalid;
        logic [1:0] x_sel;
        logic [2:0] x_out;
        logic       x_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic av, input logic ar, input logic [1:0] sel,
                                input logic [7:0] len, input logic [3:0] rv, input logic [3:0] rl,
                                input logic mr, input logic st, input logic [3:0] rr,
                                input logic mv, input logic [1:0] rs, input logic [2:0] oc,
                                input logic le);
        vec_t v;
        v.av = av; v.ar = ar; v.sel = sel; v.len = len; v.rv = rv; v.rl = rl; v.mr = mr;
        v.x_stall = st; v.x_rready = rr; v.x_mvalid = mv; v.x_sel = rs; v.x_out = oc; v.x_err = le;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic av, input logic ar, input logic [1:0] sel, input logic [7:0] len,
                       input logic [3:0] rv, input logic [3:0] rl, input logic mr);
        ar_valid = av; ar_ready = ar; ar_slave_sel = sel; ar_len = len;
        s_rvalid = rv; s_rlast = rl; m_rready = mr;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [3:0] rr, input logic mv,
                           input logic [1:0] rs, input logic [2:0] oc, input logic le);
        chk({tag, ".ar_stall"}, 32'(ar_stall), 32'(st));
        chk({tag, ".s_rready"}, 32'(s_rready), 32'(rr));
        chk({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(mv));
        chk({tag, ".rd_sel"}, 32'(rd_sel), 32'(rs));
        chk({tag, ".outstanding"}, 32'(outstanding), 32'(oc));
        chk({tag, ".len_err"}, 32'(len_err), 32'(le));
    endtask

    initial begin
        //   av ar sel len  rv       rl       mr | stall rready  mv sel out err
        // single burst: slave 2, len 3
        add(1, 1, 2'd2, 8'd3, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd2, 3'd0, 0);
        // ordering: slave 1 len 0, then slave 3 len 1; slave 3 valid early
        add(1, 1, 2'd1, 8'd0, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 2'd2, 3'd0, 0);
        add(1, 1, 2'd3, 8'd1, 4'b1000, 4'b0000, 1, 0, 4'b0010, 0, 2'd1, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b1010, 4'b0010, 1, 0, 4'b0010, 1, 2'd1, 3'd2, 0);
        add(0, 0, 2'd0, 8'd0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 1, 2'd3, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b1000, 4'b1000, 1, 0, 4'b1000, 1, 2'd3, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd3, 3'd0, 0);
        // early RLAST: slave 0 len 1, RLAST on first beat (with one stalled cycle)
        add(1, 1, 2'd0, 8'd1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd3, 3'd0, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0001, 4'b0001, 0, 0, 4'b0000, 1, 2'd0, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 1);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        // missing RLAST: slave 1 len 0, RLAST only on second beat
        add(1, 1, 2'd1, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 1, 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0010, 4'b0010, 1, 0, 4'b0010, 1, 2'd1, 3'd1, 1);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd1, 3'd0, 1);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd1, 3'd0, 0);
        // push and pop in the same cycle
        add(1, 1, 2'd2, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd1, 3'd0, 0);
        add(1, 1, 2'd0, 8'd0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        // AR valid without ready is not queued
        add(1, 0, 2'd3, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0, 0);

        // reset with all slaves asserting RVALID, before any clock edge
        ARESET = 1'b1;
        drv(0, 0, 2'd0, 8'd0, 4'b1111, 4'b1111, 1);
        #3;
        chk_all("reset", 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        tick();
        ARESET = 1'b0;
        drv(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drv(vecs[i].av, vecs[i].ar, vecs[i].sel, vecs[i].len, vecs[i].rv, vecs[i].rl, vecs[i].mr);
            #2;
            chk_all($sformatf("v%0d", i), vecs[i].x_stall, vecs[i].x_rready, vecs[i].x_mvalid,
                    vecs[i].x_sel, vecs[i].x_out, vecs[i].x_err);
            tick();
        end

        // fill the queue to FIFO_DEPTH with no responses
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 2'(i), 8'd0, 4'b0000, 4'b0000, 1);
            #2;
            chk($sformatf("fill%0d.outstanding", i), 32'(outstanding), 32'(i));
            chk($sformatf("fill%0d.ar_stall", i), 32'(ar_stall), 32'd0);
            tick();
        end
        drv(1, 1, 2'd0, 8'd0, 4'b0000, 4'b0000, 1);
        #2;
        chk_all("full", 1, 4'b0001, 0, 2'd0, 3'd4, 0);
        tick();
        // pop while full: stall stays high this cycle, push is refused
        drv(1, 1, 2'd0, 8'd0, 4'b0001, 4'b0001, 1);
        #2;
        chk_all("full_pop", 1, 4'b0001, 1, 2'd0, 3'd4, 0);
        tick();
        for (int i = 1; i < 4; i++) begin
            drv(0, 0, 2'd0, 8'd0, 4'(1 << i), 4'(1 << i), 1);
            #2;
            chk_all($sformatf("drain%0d", i), 0, 4'(1 << i), 1, 2'(i), 3'(4 - i), 0);
            tick();
        end
        drv(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1);
        #2;
        chk_all("drained", 0, 4'b0000, 0, 2'd3, 3'd0, 0);
        tick();

        // reset during beat 2 of a len=7 burst
        drv(1, 1, 2'd1, 8'd7, 4'b0000, 4'b0000, 1);
        #2;
        tick();
        drv(0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 1);
        #2;
        chk_all("mid_beat1", 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        tick();
        drv(0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 1);
        #2;
        ARESET = 1'b1;
        #1;
        chk_all("mid_rst", 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        tick();
        ARESET = 1'b0;
        drv(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1);
        #2;
        chk_all("post_rst", 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        tick();
        drv(1, 1, 2'd3, 8'd0, 4'b0000, 4'b0000, 1);
        #2;
        tick();
        drv(0, 0, 2'd0, 8'd0, 4'b1000, 4'b1000, 1);
        #2;
        chk_all("post_rst_beat", 0, 4'b1000, 1, 2'd3, 3'd1, 0);
        tick();
        drv(0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 1);
        #2;
        chk_all("post_rst_done", 0, 4'b0000, 0, 2'd3, 3'd0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_resp_sched.md
Name: axi_rd_resp_sched

Overview:
- Read-response scheduler for a 1-master / 4-slave AXI read path.
- Records each accepted AR (target slave index + ARLEN) in an in-order FIFO.
- Drives the 2-bit select of the read-data 4:1 mux from the FIFO head, so R beats return in AR order.
- Gates RVALID/RREADY per slave, retires a transaction on its RLAST handshake, and flags burst-length mismatches.

Parameters:
- FIFO_DEPTH, 4, outstanding-read capacity; power of two, ≥2.
- LEN_W, 8, ARLEN width.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the outstanding count.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  reset; asynchronous, active-high.
- ar_valid  in  1  master ARVALID, after the address decoder.
- ar_ready  in  1  ARREADY returned by the selected slave.
- ar_slave_sel  in  2  decoded target slave of the current AR.
- ar_len  in  LEN_W  ARLEN of the current AR.
- ar_stall  out  1  high forces ARREADY to the master low (FIFO full).
- s_rvalid  in  4  RVALID from slaves 0..3.
- s_rlast  in  4  RLAST from slaves 0..3.
- m_rready  in  1  master RREADY.
- s_rready  out  4  RREADY to slaves; one-hot or zero.
- m_rvalid  out  1  RVALID to master.
- rd_sel  out  2  select to the RDATA/RRESP/RLAST 4:1 mux.
- outstanding  out  CNT_W  number of queued ARs.
- len_err  out  1  one-cycle pulse on burst-length mismatch.

Behaviour:
- Reset values: FIFO empty, outstanding=0, beat_cnt=0, rd_sel=0, ar_stall=0, len_err=0, s_rready=0, m_rvalid=0.
- Push: when ar_valid & ar_ready & !ar_stall, write {ar_slave_sel, ar_len} at the tail.
- ar_stall = registered full, i.e. outstanding==FIFO_DEPTH.
- Full with simultaneous pop: ar_stall stays high that cycle. No bypass; it deasserts the next cycle.
- Head visibility: an entry pushed in cycle N becomes the head in cycle N+1, never in the same cycle.
- States:
  - IDLE: FIFO empty. rd_sel holds its last value; m_rvalid=0; s_rready=0.
  - BURST: FIFO non-empty. rd_sel = head.slave (combinational from registered head). m_rvalid = s_rvalid[rd_sel]. s_rready[rd_sel] = m_rready; other bits 0.
  - Transitions follow FIFO empty/non-empty.
- Beat handshake: m_rvalid & m_rready.
  - On each beat, beat_cnt increments.
  - On a beat with s_rlast[rd_sel]=1: pop the head and clear beat_cnt.
- len_err rules:
  - Pulse when RLAST arrives with beat_cnt != head.len.
  - Pulse when beat_cnt==head.len, the beat is taken, and RLAST is low. Do not pop; keep counting, saturating at all-ones.
- Non-head slaves: s_rvalid on them is ignored; they see RREADY=0 until they reach the head.
- Back-to-back: the next head's first beat may transfer in the cycle after the previous RLAST beat. rd_sel changes exactly at that edge.
- Push and pop in the same cycle: outstanding is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- ARESET mid-burst: immediate return to reset values. In-flight beats are discarded; no len_err.
- Latency: 0-cycle combinational ready/valid pass-through, 0-cycle rd_sel from head. No added R-channel bubbles.

Decomposition:
- Shared package axi_ic_pkg holds:
  - NUM_SLV=4, SLV_IDX_W=2.
  - typedef rd_ord_entry_t {slave_idx, len}.
- One sub-module, ord_fifo: synchronous FIFO with registered count/full/empty and parameterized depth/width.
- The scheduler keeps the gating logic, beat counter and error check. The existing 4:1 mux instances consume rd_sel externally.

Test Plan:
- Reset/idle: ARESET pulse with s_rvalid=4'b1111 -> rd_sel=0, m_rvalid=0, s_rready=0, outstanding=0.
- Single burst: AR to slave 2, len=3; slave 2 drives 4 beats, RLAST on 4th; m_rready=1 -> rd_sel=2, s_rready=4'b0100, 4 beats pass, outstanding 1->0, len_err never high.
- Ordering: ARs to slaves 1 (len 0) then 3 (len 1). Slave 3 asserts RVALID first -> s_rready[3]=0 until slave 1's RLAST beat. rd_sel=1 then switches to 3 the next cycle with no bubble.
- Full/stall: FIFO_DEPTH=4, issue 4 ARs without responses -> ar_stall=1, outstanding=4. Complete one burst -> ar_stall=0 the cycle after the pop.
- Length error: AR len=1, slave asserts RLAST on the 1st beat -> len_err one-cycle pulse, entry popped.
- Mid-burst reset: ARESET during beat 2 of len=7 -> outputs at reset values in the same cycle (async). A following AR works normally.
